// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Types and defaults shared by the PC generator and its next-PC selector.
//   pc_state_e     : BOOT / RUN / HALT controller state (2-bit encoding)
//   pc_sel_e       : which source updates the PC on the next edge
//   RESET_VECTOR_D : default PC after reset
//   TRAP_VECTOR_D  : default PC on a trap
//   align_mask()   : low-bit mask that must be zero in a redirect target
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        JMP  = 3'd2,
        TRAP = 3'd3,
        MRET = 3'd4,
        HOLD = 3'd5
    } pc_sel_e;

    localparam logic [31:0] RESET_VECTOR_D = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_D  = 32'h0000_0040;

    // For INC = 2 or 4 this is INC-1, i.e. the low log2(INC) bits. A zero
    // mask disables the check (INC = 1, or checking switched off).
    function automatic int unsigned align_mask(input int unsigned inc, input bit check);
        if (check && inc > 1) begin
            return inc - 1;
        end
        return 0;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
// Control and address bundle between the decode/branch unit (master) and
// the PC generator (slave).
//   Requests  (master -> slave): stall, halt, resume, branch, branch_offset,
//                                jump, jump_target, trap, mret
//   Results   (slave -> master): pc, pc_plus, pc_valid, epc, misaligned, state
//
// Handshake: there is no ready. Every request is a level sampled on each
// rising clock edge and acts on that edge only. A redirect that meets a
// stall is dropped, not queued, so the requester must keep it asserted
// until a non-stalled edge. pc_valid qualifies pc as a fetch address.
// -----------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int XLEN = 32
) ();

    logic            stall;
    logic            halt;
    logic            resume;
    logic            branch;
    logic [XLEN-1:0] branch_offset;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            trap;
    logic            mret;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic            pc_valid;
    logic [XLEN-1:0] epc;
    logic            misaligned;
    logic [1:0]      state;

    modport master (
        output stall, halt, resume, branch, branch_offset,
               jump, jump_target, trap, mret,
        input  pc, pc_plus, pc_valid, epc, misaligned, state
    );

    modport slave (
        input  stall, halt, resume, branch, branch_offset,
               jump, jump_target, trap, mret,
        output pc, pc_plus, pc_valid, epc, misaligned, state
    );

endinterface

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC selection: priority encode of the requests, target
// adders and the alignment check.
//   state_i          : current controller state
//   pc_i, epc_i      : current PC and saved exception PC
//   stall_i, halt_i  : hold requests
//   branch_i/offset  : PC-relative branch request and signed offset
//   jump_i/target    : absolute jump request and target
//   trap_i, mret_i   : trap entry / trap return requests
//   sel_o            : chosen PC source (HOLD = PC keeps its value)
//   target_o         : PC value to load when sel_o != HOLD
//   misaligned_o     : the TRAP selection came from a misaligned redirect
// -----------------------------------------------------------------------------
module pc_next_sel
    import core_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              INC         = 1,
    parameter int              ALIGN_CHECK = 1,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_D)
) (
    input  pc_state_e       state_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_offset_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic            mret_i,
    output pc_sel_e         sel_o,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INC, ALIGN_CHECK != 0));
    // Jump targets lose bit 0 whenever instructions are wider than one unit.
    localparam logic [XLEN-1:0] JMP_CLR    = (INC > 1) ? XLEN'(1) : '0;

    logic [XLEN-1:0] jmp_tgt_d;
    logic [XLEN-1:0] br_tgt_d;
    logic [XLEN-1:0] seq_tgt_d;
    logic [XLEN-1:0] cand_d;
    pc_sel_e         cand_sel_d;

    assign jmp_tgt_d = jump_target_i & ~JMP_CLR;
    assign br_tgt_d  = pc_i + branch_offset_i;
    assign seq_tgt_d = pc_i + XLEN'(INC);

    // Redirect candidate in RUN, ignoring trap/stall/halt (handled below).
    always_comb begin
        cand_sel_d = SEQ;
        cand_d     = seq_tgt_d;
        if (mret_i) begin
            cand_sel_d = MRET;
            cand_d     = epc_i;
        end else if (jump_i) begin
            cand_sel_d = JMP;
            cand_d     = jmp_tgt_d;
        end else if (branch_i) begin
            cand_sel_d = BR;
            cand_d     = br_tgt_d;
        end
    end

    always_comb begin
        sel_o        = HOLD;
        target_o     = pc_i;
        misaligned_o = 1'b0;
        case (state_i)
            RUN: begin
                if (trap_i) begin
                    sel_o    = TRAP;
                    target_o = TRAP_VECTOR;
                end else if (stall_i || halt_i) begin
                    sel_o = HOLD;
                end else if (cand_sel_d != SEQ && (cand_d & ALIGN_MASK) != '0) begin
                    // A bad redirect turns into a trap instead of loading.
                    sel_o        = TRAP;
                    target_o     = TRAP_VECTOR;
                    misaligned_o = 1'b1;
                end else begin
                    sel_o    = cand_sel_d;
                    target_o = cand_d;
                end
            end
            HALT: begin
                if (trap_i) begin
                    sel_o    = TRAP;
                    target_o = TRAP_VECTOR;
                end
            end
            default: begin
                sel_o = HOLD;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter generator: architectural PC, exception PC and the
// BOOT/RUN/HALT controller. Next-PC choice lives in pc_next_sel.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; overrides every request
//   bus   : pc_gen_if slave modport (requests in, pc/epc/status out)
// Parameters: XLEN (PC width), INC (1, 2 or 4 address units per
// instruction), RESET_VECTOR, TRAP_VECTOR, ALIGN_CHECK.
// -----------------------------------------------------------------------------
module pc_gen
    import core_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              INC          = 1,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_D),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_D),
    parameter int              ALIGN_CHECK  = 1
) (
    input  logic    clk,
    input  logic    reset,
    pc_gen_if.slave bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic            misaligned_q;
    logic            pc_valid_q;
    pc_state_e       state_q;

    pc_sel_e         sel_d;
    logic [XLEN-1:0] pc_d;
    logic            misaligned_d;

    pc_next_sel #(
        .XLEN        (XLEN),
        .INC         (INC),
        .ALIGN_CHECK (ALIGN_CHECK),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .epc_i           (epc_q),
        .stall_i         (bus.stall),
        .halt_i          (bus.halt),
        .branch_i        (bus.branch),
        .branch_offset_i (bus.branch_offset),
        .jump_i          (bus.jump),
        .jump_target_i   (bus.jump_target),
        .trap_i          (bus.trap),
        .mret_i          (bus.mret),
        .sel_o           (sel_d),
        .target_o        (pc_d),
        .misaligned_o    (misaligned_d)
    );

    // Controller plus PC/EPC registers. pc_valid is registered alongside
    // the state so it is high exactly while the state is RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            misaligned_q <= 1'b0;
            pc_valid_q   <= 1'b0;
            state_q      <= BOOT;
        end else begin
            misaligned_q <= misaligned_d;
            if (sel_d != HOLD) begin
                pc_q <= pc_d;
            end
            if (sel_d == TRAP) begin
                epc_q <= pc_q;
            end
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    // halt only counts when neither trap nor stall outranks it.
                    if (!bus.trap && !bus.stall && bus.halt) begin
                        state_q    <= HALT;
                        pc_valid_q <= 1'b0;
                    end
                end
                HALT: begin
                    if (bus.trap || bus.resume) begin
                        state_q    <= RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= BOOT;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus    = pc_q + XLEN'(INC);
    assign bus.pc_valid   = pc_valid_q;
    assign bus.epc        = epc_q;
    assign bus.misaligned = misaligned_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
    import core_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst4, rst8;
    int total = 0;
    int bad   = 0;

    pc_gen_if #(.XLEN(32)) bus1 ();
    pc_gen_if #(.XLEN(32)) bus4 ();
    pc_gen_if #(.XLEN(8))  bus8 ();

    pc_gen #(.XLEN(32), .INC(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    pc_gen #(.XLEN(32), .INC(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));
    pc_gen #(.XLEN(8), .INC(1), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h40))
        dut8 (.clk(clk), .reset(rst8), .bus(bus8));

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall, halt, resume, branch;
        logic [31:0] off;
        logic        jump;
        logic [31:0] tgt;
        logic        trap, mret;
        logic [31:0] e_pc, e_epc;
        logic        e_mis;
        logic [1:0]  e_st;
        logic        e_v;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic st, input logic ha, input logic re, input logic br,
                       input logic [31:0] off, input logic jp, input logic [31:0] tgt,
                       input logic tr, input logic mr, input logic [31:0] e_pc,
                       input logic [31:0] e_epc, input logic e_mis, input logic [1:0] e_st,
                       input logic e_v);
        vec_t v;
        v.stall = st; v.halt = ha; v.resume = re; v.branch = br; v.off = off;
        v.jump = jp; v.tgt = tgt; v.trap = tr; v.mret = mr;
        v.e_pc = e_pc; v.e_epc = e_epc; v.e_mis = e_mis; v.e_st = e_st; v.e_v = e_v;
        vt.push_back(v);
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle1();
        bus1.stall = 0; bus1.halt = 0; bus1.resume = 0; bus1.branch = 0;
        bus1.branch_offset = '0; bus1.jump = 0; bus1.jump_target = '0;
        bus1.trap = 0; bus1.mret = 0;
    endtask

    task automatic idle4();
        bus4.stall = 0; bus4.halt = 0; bus4.resume = 0; bus4.branch = 0;
        bus4.branch_offset = '0; bus4.jump = 0; bus4.jump_target = '0;
        bus4.trap = 0; bus4.mret = 0;
    endtask

    task automatic idle8();
        bus8.stall = 0; bus8.halt = 0; bus8.resume = 0; bus8.branch = 0;
        bus8.branch_offset = '0; bus8.jump = 0; bus8.jump_target = '0;
        bus8.trap = 0; bus8.mret = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    initial begin
        rst1 = 1; rst4 = 1; rst8 = 1;
        idle1(); idle4(); idle8();

        // Reset held two cycles.
        step(); step();
        chk("rst1_pc", bus1.pc, 32'h0);
        chk("rst1_valid", {31'b0, bus1.pc_valid}, 32'h0);
        chk("rst1_state", {30'b0, bus1.state}, 32'd0);
        chk("rst1_epc", bus1.epc, 32'h0);
        chk("rst1_mis", {31'b0, bus1.misaligned}, 32'h0);
        chk("rst4_pc", bus4.pc, 32'h0);

        // INC=1: BOOT cycle then 0,1,2,3.
        rst1 = 0;
        chk("boot_valid", {31'b0, bus1.pc_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("seq%0d_pc", i), bus1.pc, 32'(i));
            chk($sformatf("seq%0d_valid", i), {31'b0, bus1.pc_valid}, 32'h1);
        end
        chk("seq_pc_plus", bus1.pc_plus, 32'h4);

        // Halt at pc=8, hold 5 cycles, resume.
        bus1.jump = 1; bus1.jump_target = 32'h8;
        step();
        chk("h_jump_pc", bus1.pc, 32'h8);
        idle1(); bus1.halt = 1;
        step();
        chk("h_state", {30'b0, bus1.state}, 32'd2);
        chk("h_pc", bus1.pc, 32'h8);
        chk("h_valid", {31'b0, bus1.pc_valid}, 32'h0);
        idle1(); bus1.branch = 1; bus1.branch_offset = 32'h5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("hold%0d_pc", i), bus1.pc, 32'h8);
            chk($sformatf("hold%0d_valid", i), {31'b0, bus1.pc_valid}, 32'h0);
            chk($sformatf("hold%0d_state", i), {30'b0, bus1.state}, 32'd2);
        end
        idle1(); bus1.resume = 1;
        step();
        chk("res_state", {30'b0, bus1.state}, 32'd1);
        chk("res_pc", bus1.pc, 32'h8);
        chk("res_valid", {31'b0, bus1.pc_valid}, 32'h1);
        idle1();
        step();
        chk("res_next_pc", bus1.pc, 32'h9);

        // INC=4 table.
        //   st ha re br off            jp tgt           tr mr  pc            epc           mis st v
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h0,         32'h0,   0, 1, 1);
        add(0, 0, 1, 0, 32'h0,          0, 32'h0,         0, 0, 32'h4,         32'h0,   0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h100,       0, 0, 32'h100,       32'h0,   0, 1, 1);
        add(0, 0, 0, 1, 32'hFFFF_FFF8,  0, 32'h0,         0, 0, 32'hF8,        32'h0,   0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h100,       0, 0, 32'h100,       32'h0,   0, 1, 1);
        add(0, 0, 0, 1, 32'h6,          0, 32'h0,         0, 0, 32'h40,        32'h100, 1, 1, 1);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h44,        32'h100, 0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h20,        0, 0, 32'h20,        32'h100, 0, 1, 1);
        add(0, 0, 0, 1, 32'h1000,       1, 32'h205,       0, 0, 32'h204,       32'h100, 0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h10,        0, 0, 32'h10,        32'h100, 0, 1, 1);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,         1, 0, 32'h40,        32'h10,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 1, 32'h10,        32'h10,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         1, 0, 32'h40,        32'h10,  0, 1, 1);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,         0, 1, 32'h40,        32'h10,  0, 1, 1);
        add(1, 0, 0, 0, 32'h0,          1, 32'h300,       0, 0, 32'h40,        32'h10,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         1, 1, 32'h40,        32'h40,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h80,        0, 0, 32'h80,        32'h40,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h202,       0, 0, 32'h40,        32'h80,  1, 1, 1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h60,        0, 0, 32'h60,        32'h80,  0, 1, 1);
        add(0, 1, 0, 0, 32'h0,          0, 32'h0,         0, 1, 32'h60,        32'h80,  0, 2, 0);
        add(0, 0, 0, 1, 32'h10,         1, 32'h0,         0, 1, 32'h60,        32'h80,  0, 2, 0);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         1, 0, 32'h40,        32'h60,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h44,        32'h60,  0, 1, 1);
        add(0, 0, 0, 1, 32'hFFFF_FFFC,  0, 32'h0,         0, 0, 32'h40,        32'h60,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 1, 32'h60,        32'h60,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h60,  0, 1, 1);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h0,         32'h60,  0, 1, 1);
        add(0, 0, 0, 1, 32'h3,          0, 32'h0,         0, 0, 32'h40,        32'h0,   1, 1, 1);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h44,        32'h0,   0, 1, 1);

        rst4 = 0;
        for (int i = 0; i < vt.size(); i++) begin
            bus4.stall = vt[i].stall; bus4.halt = vt[i].halt; bus4.resume = vt[i].resume;
            bus4.branch = vt[i].branch; bus4.branch_offset = vt[i].off;
            bus4.jump = vt[i].jump; bus4.jump_target = vt[i].tgt;
            bus4.trap = vt[i].trap; bus4.mret = vt[i].mret;
            step();
            chk($sformatf("v%0d_pc", i), bus4.pc, vt[i].e_pc);
            chk($sformatf("v%0d_epc", i), bus4.epc, vt[i].e_epc);
            chk($sformatf("v%0d_mis", i), {31'b0, bus4.misaligned}, {31'b0, vt[i].e_mis});
            chk($sformatf("v%0d_state", i), {30'b0, bus4.state}, {30'b0, vt[i].e_st});
            chk($sformatf("v%0d_valid", i), {31'b0, bus4.pc_valid}, {31'b0, vt[i].e_v});
            chk($sformatf("v%0d_pc_plus", i), bus4.pc_plus, vt[i].e_pc + 32'h4);
        end
        idle4();

        // XLEN=8: inputs ignored in BOOT, wrap at 0xFF, reset from HALT.
        rst8 = 0;
        bus8.jump = 1; bus8.jump_target = 8'h33;
        step();
        chk("x8_boot_pc", {24'b0, bus8.pc}, 32'h0);
        chk("x8_boot_state", {30'b0, bus8.state}, 32'd1);
        bus8.jump_target = 8'hFF;
        step();
        chk("x8_jump_pc", {24'b0, bus8.pc}, 32'hFF);
        chk("x8_pc_plus_wrap", {24'b0, bus8.pc_plus}, 32'h0);
        idle8();
        step();
        chk("x8_wrap_pc", {24'b0, bus8.pc}, 32'h0);
        bus8.halt = 1;
        step();
        chk("x8_halt_state", {30'b0, bus8.state}, 32'd2);
        bus8.halt = 0; bus8.resume = 1; rst8 = 1;
        step();
        chk("x8_rst_pc", {24'b0, bus8.pc}, 32'h0);
        chk("x8_rst_state", {30'b0, bus8.state}, 32'd0);
        chk("x8_rst_valid", {31'b0, bus8.pc_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the single-cycle core. It holds the architectural PC register and selects the next PC from sequential increment, PC-relative branch, absolute jump, trap vector or trap return. It supports stall and halt and carries a small boot/run/halt state machine. It also provides an exception-PC register and a misaligned-target check. It sits between the decode/branch unit and the instruction memory address port.

Parameters:
XLEN, 32, width of the PC and all address/offset ports.
INC, 1, address units per instruction: 1 means word-indexed PC, 4 means byte-addressed PC. Only 1, 2 and 4 are legal.
RESET_VECTOR, 0, PC value loaded by reset.
TRAP_VECTOR, 32'h40, PC value loaded on a trap.
ALIGN_CHECK, 1, when 1 and INC>1, redirect targets with nonzero low log2(INC) bits raise a misaligned trap.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC; blocks all updates except reset and trap
halt  in  1  request entry to HALT state
resume  in  1  leave HALT state
branch  in  1  take PC-relative branch
branch_offset  in  XLEN  signed offset added to current pc
jump  in  1  take absolute jump
jump_target  in  XLEN  absolute target; bit 0 is forced to 0 when INC>1
trap  in  1  external/illegal-instruction trap request
mret  in  1  return from trap
pc  out  XLEN  current PC (registered)
pc_plus  out  XLEN  pc+INC (combinational from pc; return address for link)
pc_valid  out  1  pc is a fetchable address this cycle
epc  out  XLEN  saved exception PC (registered)
misaligned  out  1  one-cycle pulse: a misaligned-target trap was taken
state  out  2  BOOT=0, RUN=1, HALT=2

Behaviour:
- Reset (sampled at posedge): pc=RESET_VECTOR, epc=0, misaligned=0, state=BOOT, pc_valid=0. Reset overrides every other input.
- BOOT: lasts exactly one cycle; pc is held; next state is RUN. pc_valid=1 from the first RUN cycle. All other inputs are ignored in BOOT.
- RUN, per posedge, first match wins:
  1) trap: epc<=pc; pc<=TRAP_VECTOR.
  2) stall: pc and epc hold. Any redirect presented in this cycle is dropped; the requester must re-present it.
  3) halt: state<=HALT; pc holds.
  4) mret: pc<=epc.
  5) jump: target = jump_target with bit 0 cleared if INC>1.
  6) branch: target = pc + branch_offset, modulo 2^XLEN.
  7) otherwise: pc<=pc+INC, modulo 2^XLEN (wrap from all-ones+INC to INC-1..0 is legal and silent).
- Misalignment (ALIGN_CHECK=1, INC>1): if a selected jump, branch or mret target has nonzero low log2(INC) bits, the update is replaced by a trap: epc<=pc, pc<=TRAP_VECTOR, misaligned=1 for one cycle. With INC=1 the check is disabled.
- HALT: pc_valid=0 and pc holds. trap is still taken (epc<=pc, pc<=TRAP_VECTOR, state<=RUN). resume moves to RUN next cycle with pc unchanged. All other inputs are ignored.
- Simultaneous branch and jump: jump wins. trap together with mret: trap wins, and epc is overwritten with the current pc.
- Latency: every redirect is visible on pc one cycle after the request edge.
- All XLEN arithmetic truncates; no overflow flag.

Decomposition:
- Shared package core_pkg: state enum (BOOT/RUN/HALT), next-PC select enum (SEQ, BR, JMP, TRAP, MRET, HOLD), and default vectors RESET_VECTOR_D and TRAP_VECTOR_D.
- One natural sub-module: pc_next_sel. It is purely combinational and takes the priority encode plus target adders and the alignment check, returning the select, the target and a misaligned flag. The parent holds pc, epc and the FSM.

Test Plan:
- Reset held 2 cycles then released, INC=1 -> pc=0 with pc_valid=0 for the BOOT cycle; then pc=0,1,2,3 with pc_valid=1.
- INC=4, pc=0x100, branch=1, branch_offset=-8 -> next pc=0xF8. Same with offset 6 -> pc=0x40, epc=0x100, misaligned pulses for 1 cycle.
- pc=0x20, jump=1 and branch=1 together, jump_target=0x205 (INC=4) -> pc=0x204? No: bit0 cleared gives 0x204, which is aligned, so pc=0x204; branch is ignored.
- pc=0x10, trap=1 and stall=1 -> pc=0x40, epc=0x10. Next cycle mret=1 -> pc=0x10. mret with stall=1 -> pc holds at 0x40.
- halt in RUN at pc=0x8 -> state=HALT, pc holds at 0x8 for 5 cycles with pc_valid=0. resume -> RUN; next pc=0x8+INC.
- XLEN=8, INC=1, pc=0xFF, no redirect -> pc=0x00. Assert reset mid-HALT -> pc=RESET_VECTOR, state=BOOT.
